// File: rtl/pio_poll_pkg.sv
// pio_poll_pkg: shared types and constants for the push-button PIO poller
package pio_poll_pkg;
  typedef enum logic [1:0] {IDLE, READ, DATA} state_e;
  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
  localparam int CNT_W = 4;
endpackage

// File: rtl/pio_poll_master_poll_timer.sv
// poll_timer: free-running poll-rate divider, held while enable is low
module poll_timer #(
  parameter int POLL_DIV = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);
  localparam int TW = $clog2(POLL_DIV);
  logic [TW-1:0] timer_q, timer_d;
  always_comb begin
    tick    = enable && timer_q == '0;
    timer_d = !enable ? timer_q : (tick ? TW'(POLL_DIV - 1) : timer_q - 1'b1);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) timer_q <= TW'(POLL_DIV - 1);
    else          timer_q <= timer_d;
endmodule

// File: rtl/pio_poll_master.sv
// pio_poll_master: Avalon-MM master polling the button PIO, debouncing
// samples into a stable vector with change/edge pulses.
module pio_poll_master
  import pio_poll_pkg::*;
#(
  parameter int         WIDTH        = 3,
  parameter int         POLL_DIV     = 50000,
  parameter int         DEBOUNCE_CNT = 4,
  parameter logic [1:0] PIO_ADDR     = PIO_DATA_ADDR
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  output logic [1:0]       avm_address,
  output logic             avm_read,
  input  logic [31:0]      avm_readdata,
  input  logic             avm_waitrequest,
  output logic [WIDTH-1:0] buttons,
  output logic             changed,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             overrun
);
  localparam logic [CNT_W-1:0] DB = CNT_W'(DEBOUNCE_CNT);
  state_e state_q, state_d;
  logic tick, upd, unused_hi;
  logic [WIDTH-1:0] sample, cand_q, cand_d, buttons_q, buttons_d, rise_q, rise_d, fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_n;
  logic changed_q, changed_d, overrun_q, overrun_d;
  poll_timer #(.POLL_DIV(POLL_DIV)) u_timer (
    .clk(clk), .reset_n(reset_n), .enable(enable), .tick(tick)
  );
  assign unused_hi = ^avm_readdata[31:WIDTH];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = tick ? READ : IDLE;
      READ:    state_d = avm_waitrequest ? READ : DATA;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    avm_read    = state_q == READ;
    avm_address = PIO_ADDR;
    buttons     = buttons_q;
    changed     = changed_q;
    rise        = rise_q;
    fall        = fall_q;
    overrun     = overrun_q;
  end
  // The new candidate is always the sample: either it matched or it replaces it.
  always_comb begin
    sample    = avm_readdata[WIDTH-1:0];
    cnt_n     = sample != cand_q ? CNT_W'(1) : (cnt_q >= DB ? DB : cnt_q + 1'b1);
    upd       = state_q == DATA && cnt_n >= DB && sample != buttons_q;
    cand_d    = state_q == DATA ? sample : cand_q;
    cnt_d     = state_q == DATA ? cnt_n : cnt_q;
    buttons_d = upd ? sample : buttons_q;
    changed_d = upd;
    rise_d    = upd ? sample & ~buttons_q : '0;
    fall_d    = upd ? ~sample & buttons_q : '0;
    overrun_d = overrun_q | (tick && state_q != IDLE);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cand_q    <= '0;
      cnt_q     <= '0;
      buttons_q <= '0;
      changed_q <= 1'b0;
      rise_q    <= '0;
      fall_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      buttons_q <= buttons_d;
      changed_q <= changed_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      overrun_q <= overrun_d;
    end
endmodule

// File: tb/tb_pio_poll_master.sv
// tb_pio_poll_master: randomized bench with a sample-history debounce model
module tb_pio_poll_master;
  localparam int W = 3, PD = 8, DB = 3;
  logic clk = 0, reset_n = 1, enable = 1, avm_waitrequest = 0;
  logic avm_read, changed, overrun;
  logic [1:0] avm_address;
  logic [31:0] avm_readdata = 0;
  logic [W-1:0] buttons, rise, fall;
  pio_poll_master #(.WIDTH(W), .POLL_DIV(PD), .DEBOUNCE_CNT(DB), .PIO_ADDR(2'd0)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .avm_address(avm_address),
    .avm_read(avm_read), .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .buttons(buttons), .changed(changed), .rise(rise), .fall(fall), .overrun(overrun)
  );
  always #5 clk = ~clk;
  int n_vec = 0, n_err = 0, cyc_n = 0, rd_start = 0, last_gap = 0, rd_len = 0, last_len = 0;
  int n_reads = 0, n_chg = 0, first_rd = -1, ws_left = 0, c0;
  logic rd_now = 0, rd_prev = 0, accepted = 0, pend = 0, upper_ones = 0;
  logic [W-1:0] btn_in = 0, pend_val = 0, exp_btn = 0, exp_rise = 0, exp_fall = 0;
  logic exp_chg = 0;
  logic [W-1:0] hist[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  // buttons follow any value seen in the last DB samples in a row
  task automatic apply(input logic [W-1:0] v);
    logic stable;
    hist.push_back(v);
    if (hist.size() > DB) void'(hist.pop_front());
    stable = hist.size() == DB;
    foreach (hist[i]) if (hist[i] != v) stable = 0;
    exp_chg = stable && v != exp_btn;
    exp_rise = exp_chg ? v & ~exp_btn : '0;
    exp_fall = exp_chg ? ~v & exp_btn : '0;
    if (exp_chg) exp_btn = v;
  endtask
  task automatic cyc();
    logic [31:0] d;
    @(negedge clk);
    chk("buttons", buttons, exp_btn);
    chk("changed", changed, exp_chg);
    chk("rise", rise, exp_rise);
    chk("fall", fall, exp_fall);
    rd_now = avm_read;
    if (rd_now) rd_len++;
    else if (rd_len > 0) begin last_len = rd_len; rd_len = 0; end
    if (rd_now && !rd_prev) begin
      last_gap = cyc_n - rd_start;
      rd_start = cyc_n;
      n_reads++;
      if (first_rd < 0) first_rd = cyc_n;
    end
    rd_prev = rd_now;
    if (changed) n_chg++;
    d = $urandom;
    if (upper_ones) d[31:W] = '1;
    d[W-1:0] = pend_val;
    avm_readdata = pend ? d : $urandom;
    avm_waitrequest = rd_now && ws_left > 0;
    @(posedge clk);
    cyc_n++;
    accepted = rd_now && !avm_waitrequest;
    if (rd_now && avm_waitrequest) ws_left--;
    if (pend) apply(pend_val);
    else begin exp_chg = 0; exp_rise = '0; exp_fall = '0; end
    pend = accepted;
    pend_val = btn_in;
  endtask
  task automatic poll(input logic [W-1:0] v);
    btn_in = v;
    accepted = 0;
    for (int i = 0; i < 64 && !accepted; i++) cyc();
    chk("poll_accepted", accepted, 1);
    cyc();
    #1;
  endtask
  task automatic wait_start(input string tag);
    int s = n_reads;
    for (int i = 0; i < 64 && n_reads == s; i++) cyc();
    chk(tag, n_reads != s, 1);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset_n = 0;
    #1;
    chk("rst_read", avm_read, 0);
    chk("rst_buttons", buttons, 0);
    chk("rst_changed", changed, 0);
    chk("rst_rise", rise, 0);
    chk("rst_fall", fall, 0);
    chk("rst_overrun", overrun, 0);
    exp_btn = '0; exp_chg = 0; exp_rise = '0; exp_fall = '0;
    hist.delete();
    pend = 0; ws_left = 0; avm_waitrequest = 0; rd_prev = 0; rd_len = 0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1;
    cyc_n = 0; first_rd = -1;
  endtask
  initial begin
    do_reset();
    wait_start("first_read_seen");
    chk("first_read_cyc", first_rd, PD);
    chk("address", avm_address, 0);
    poll(3'b101); chk("press1_btn", buttons, 0);
    poll(3'b101); chk("press2_btn", buttons, 0);
    poll(3'b101);
    chk("press_btn", buttons, 3'b101);
    chk("press_chg", changed, 1);
    chk("press_rise", rise, 3'b101);
    chk("press_fall", fall, 0);
    cyc(); #1 chk("press_pulse_end", changed, 0);
    btn_in = 0; ws_left = 3;
    wait_start("midpoll_seen");
    chk("midpoll_read", avm_read, 1);
    do_reset();
    wait_start("reset_read_seen");
    chk("reset_first_read", first_rd, PD);
    c0 = n_chg;
    poll(3'b101); poll(3'b000); poll(3'b101); poll(3'b101);
    cyc();
    chk("bounce_btn", buttons, 0);
    chk("bounce_nochg", n_chg, c0);
    poll(3'b101);
    chk("bounce_btn_set", buttons, 3'b101);
    chk("bounce_rise", rise, 3'b101);
    cyc();
    chk("bounce_one_chg", n_chg, c0 + 1);
    c0 = n_chg;
    repeat (3) poll(3'b001);
    chk("release_btn", buttons, 3'b001);
    chk("release_fall", fall, 3'b100);
    chk("release_rise", rise, 0);
    repeat (3) cyc();
    chk("release_one_chg", n_chg, c0 + 1);
    chk("ovr_before", overrun, 0);
    ws_left = 10;
    poll(3'b001);
    cyc();
    chk("ws_read_len", last_len, 11);
    chk("ws_overrun", overrun, 1);
    poll(3'b001);
    chk("ws_next_gap", last_gap, 2 * PD);
    poll(3'b001);
    chk("normal_gap", last_gap, PD);
    chk("normal_len", last_len, 1);
    chk("ovr_sticky", overrun, 1);
    wait_start("en_sync");
    enable = 0;
    c0 = n_reads;
    repeat (20) cyc();
    chk("en_no_read", n_reads, c0);
    enable = 1;
    upper_ones = 1;
    wait_start("en_resume");
    chk("en_gap", last_gap, PD + 20);
    repeat (3) poll(3'b110);
    chk("upper_ignored", buttons, 3'b110);
    upper_ones = 0;
    for (int g = 0; g < 40; g++) begin
      logic [W-1:0] v = W'($urandom);
      int k = $urandom_range(1, 4);
      for (int j = 0; j < k; j++) begin
        ws_left = $urandom_range(0, 2);
        poll(v);
      end
    end
    chk("ovr_end", overrun, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
